// File: rtl/pcint_ctrl_pkg.sv
// Shared constants, types and helpers for the pin-change interrupt controller.
package pcint_ctrl_pkg;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned PORT_W    = 8;
    localparam int unsigned OFF_W     = 5;

    // Register window placement and byte offsets.
    localparam logic [31:0] PCINT_BASE     = 32'h4000_1000;
    localparam logic [31:0] PCINT_WIN_LAST = 32'h0000_0013;

    localparam logic [OFF_W-1:0] PCINT_PCICR  = 5'h00;
    localparam logic [OFF_W-1:0] PCINT_PCIFR  = 5'h04;
    localparam logic [OFF_W-1:0] PCINT_PCMSK0 = 5'h08;
    localparam logic [OFF_W-1:0] PCINT_PCMSK1 = 5'h0C;
    localparam logic [OFF_W-1:0] PCINT_PCMSK2 = 5'h10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } bus_state_e;

    // One register write, committed on the edge that raises mem_ready.
    typedef struct packed {
        logic             we;
        logic [OFF_W-1:0] off;
        logic [7:0]       data;
    } reg_wr_t;

    // True when the byte address falls inside the register window.
    function automatic logic pcint_in_window(input logic [31:0] addr);
        return (addr >= PCINT_BASE) && (addr <= (PCINT_BASE + PCINT_WIN_LAST));
    endfunction

    // Byte offset of an in-window address.
    function automatic logic [OFF_W-1:0] pcint_offset(input logic [31:0] addr);
        logic [31:0] diff;
        diff = addr - PCINT_BASE;
        return diff[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/pcint_sync_edge.sv
// Per-port pin synchroniser plus previous-value register; flags any level change.
module pcint_sync_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] change
);

    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 3)) begin : g_bad_depth
        $error("pcint_sync_edge: SYNC_STAGES must be 2 or 3");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Synchroniser chain followed by the previous-value flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign change = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/pcint_ctrl.sv
// Pin-change interrupt controller for Ports B, C, D with PCICR/PCIFR/PCMSKn registers.
module pcint_ctrl
    import pcint_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    input  logic [7:0]  gpio_pin_in_b,
    input  logic [7:0]  gpio_pin_in_c,
    input  logic [7:0]  gpio_pin_in_d,
    input  logic [2:0]  irq_ack,
    output logic [2:0]  irq
);

    bus_state_e state_q, state_d;

    logic        ready_q, ready_d;
    logic [7:0]  rdata_q, rdata_d;

    logic [NUM_PORTS-1:0] pcicr_q;
    logic [NUM_PORTS-1:0] pcifr_q, pcifr_d;
    logic [PORT_W-1:0]    pcmsk0_q, pcmsk1_q, pcmsk2_q;

    logic [PORT_W-1:0]    change_b, change_c, change_d;
    logic [NUM_PORTS-1:0] set_c;
    logic [NUM_PORTS-1:0] w1c_c;
    logic                 sel_c;
    logic                 access_c;
    logic [OFF_W-1:0]     off_c;
    logic [7:0]           rd_val_c;
    reg_wr_t              wr_c;
    logic                 unused_bits_c;

    pcint_sync_edge #(.WIDTH(PORT_W), .SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (gpio_pin_in_b),
        .change (change_b)
    );

    pcint_sync_edge #(.WIDTH(PORT_W), .SYNC_STAGES(SYNC_STAGES)) u_sync_c (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (gpio_pin_in_c),
        .change (change_c)
    );

    pcint_sync_edge #(.WIDTH(PORT_W), .SYNC_STAGES(SYNC_STAGES)) u_sync_d (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (gpio_pin_in_d),
        .change (change_d)
    );

    // Only the low data byte and strobe bit 0 carry meaning.
    assign unused_bits_c = ^{mem_wdata[31:8], mem_wstrb[3:1]};

    assign sel_c    = mem_valid && pcint_in_window(mem_addr);
    assign access_c = sel_c && !ready_q;
    assign off_c    = pcint_offset(mem_addr);

    // Read mux over current register contents (pre-update values).
    always_comb begin
        rd_val_c = 8'h00;
        case (off_c)
            PCINT_PCICR:  rd_val_c = {5'b0, pcicr_q};
            PCINT_PCIFR:  rd_val_c = {5'b0, pcifr_q};
            PCINT_PCMSK0: rd_val_c = pcmsk0_q;
            PCINT_PCMSK1: rd_val_c = pcmsk1_q;
            PCINT_PCMSK2: rd_val_c = pcmsk2_q;
            default:      rd_val_c = 8'h00;
        endcase
    end

    // Bus FSM state register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus FSM next state: accept once, hold ready until valid drops.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        wr_c    = '0;
        case (state_q)
            S_IDLE: begin
                if (access_c) begin
                    state_d    = S_ACK;
                    ready_d    = 1'b1;
                    rdata_d    = rd_val_c;
                    wr_c.we    = mem_wstrb[0];
                    wr_c.off   = off_c;
                    wr_c.data  = mem_wdata[7:0];
                end
            end
            S_ACK: begin
                if (!mem_valid) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                    rdata_d = 8'h00;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
                rdata_d = 8'h00;
            end
        endcase
    end

    // Per-port group set from masked changes; mask sampled in the same cycle.
    assign set_c[0] = |(change_b & pcmsk0_q);
    assign set_c[1] = |(change_c & pcmsk1_q);
    assign set_c[2] = |(change_d & pcmsk2_q);

    assign w1c_c = (wr_c.we && (wr_c.off == PCINT_PCIFR)) ? wr_c.data[2:0] : 3'b000;

    // Hardware set wins over software clear and irq_ack.
    assign pcifr_d = set_c | (pcifr_q & ~w1c_c & ~irq_ack);

    // Configuration and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcicr_q  <= '0;
            pcifr_q  <= '0;
            pcmsk0_q <= '0;
            pcmsk1_q <= '0;
            pcmsk2_q <= '0;
        end else begin
            pcifr_q <= pcifr_d;
            if (wr_c.we) begin
                case (wr_c.off)
                    PCINT_PCICR:  pcicr_q  <= wr_c.data[2:0];
                    PCINT_PCMSK0: pcmsk0_q <= wr_c.data;
                    PCINT_PCMSK1: pcmsk1_q <= wr_c.data;
                    PCINT_PCMSK2: pcmsk2_q <= wr_c.data;
                    default: ;
                endcase
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = {24'h0, rdata_q};
    assign irq       = pcifr_q & pcicr_q;

endmodule

// File: doc/pcint_ctrl.md
# pcint_ctrl

Pin-change interrupt controller for Ports B, C and D. It taps the raw pin inputs that feed the GPIO block, synchronises them, and detects any edge on masked pins. It raises per-port pending flags and interrupt requests to the RISC-V core. It sits on the same memory bus as the GPIO block, with the same valid/ready handshake, and mirrors the ATmega328P PCICR/PCIFR/PCMSKn register model.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth per pin. Legal range is 2–3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; one clock, no other reset source.
- mem_valid  in  1  bus request.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data; only [7:0] is used.
- mem_wstrb  in  4  byte strobes; 0 means read; bit 0 gates the write.
- mem_rdata  out  32  read data; zero-extended to 32 bits.
- mem_ready  out  1  transaction complete.
- gpio_pin_in_b, gpio_pin_in_c, gpio_pin_in_d  in  8 each  raw asynchronous pin levels, shared with the GPIO block.
- irq_ack  in  3  one-cycle pulses that clear PCIF[2:0]. Bit 0 is Port B, bit 1 is Port C, bit 2 is Port D.
- irq  out  3  level interrupt requests, one per port.

## Operation
- Registers are 8 bits each, at word offsets from `PCINT_BASE` in memory_map.vh:
  - `PCINT_PCICR` (+0x0): enables; bits [2:0] are R/W, bits [7:3] read as 0.
  - `PCINT_PCIFR` (+0x4): flags; bits [2:0]; writing 1 clears a bit, writing 0 has no effect.
  - `PCINT_PCMSK0` (+0x8): Port B mask, R/W.
  - `PCINT_PCMSK1` (+0xC): Port C mask, R/W.
  - `PCINT_PCMSK2` (+0x10): Port D mask, R/W.
- Block select is mem_valid asserted with mem_addr in `PCINT_BASE`..+0x13. Unmapped offsets inside the window read 0 and ignore writes.
- Pin path, per pin:
  - SYNC_STAGES flops, followed by a one-flop "previous" register.
  - change = sync XOR prev.
- Group set, for port n: set_n = |(change_n & PCMSKn). The mask is sampled in the same cycle the change is seen.
- Flag update priority, per bit: hardware set wins over both the software W1C and irq_ack in the same cycle.
- irq[n] = PCIFR[n] & PCICR[n], combinational from registers and therefore glitch-free.
- Edges on unmasked pins are discarded; they are not latched for later unmasking.
- An edge that occurs while PCICR[n]=0 still sets PCIFR[n]. The irq fires once the enable bit is set.

## Timing
- Reset values are all zero: every register, synchroniser flop and prev flop, plus mem_ready, mem_rdata and irq. The prev register resets to 0, so a pin already high at reset release registers as a change, but the masks are 0 and no flag is set.
- Pin edge to PCIFR set: SYNC_STAGES+1 rising edges. With the default depth of 2, the flag is visible after the 3rd edge.
- PCIFR set to irq: 0 cycles.
- Bus handshake:
  - A new access is mem_valid & select & !mem_ready. mem_ready rises on the next edge and stays high while mem_valid is held. It falls one cycle after mem_valid drops.
  - The write commits exactly once, on the edge that raises mem_ready. Holding mem_valid does not repeat the write.
  - mem_rdata is registered on that same edge and is stable while mem_ready is high. It returns 0 when mem_ready is low.
- A PCIFR read returns the pre-update value, even if a set lands on the same edge.
- irq_ack is honoured on any cycle, independent of the bus.
- rst_n asserted mid-transaction clears all state immediately. The partial write is lost and mem_ready drops asynchronously.

## Structure
- Add `PCINT_BASE` and the five register macros to memory_map.vh; the register offsets live there only.
- Sub-module pcint_sync_edge, instantiated three times:
  - contents: one port's synchroniser chain and prev register;
  - parameters: width 8 and SYNC_STAGES;
  - output: change[7:0].
- The top level holds the bus FSM (IDLE→ACK→IDLE), the registers and the flag logic.

## Test plan
- Reset state: read all five registers and check each is 0x00; irq=3'b000.
- Masked edge:
  - set PCMSK1=0x01 and PCICR=0x02;
  - toggle gpio_pin_in_c[0] from 0 to 1;
  - check PCIFR=0x02 after 3 clocks and irq=3'b010;
  - toggle gpio_pin_in_c[1]: no further effect.
- Clears:
  - write PCIFR=0x02 and check PCIFR=0x00 and irq=0;
  - repeat the edge, pulse irq_ack[1], and check the flag clears.
- Collision: put an edge on Port D pin 3 (PCMSK2=0x08) so it sets PCIF2 on the same edge as a W1C write of 0x04. Required: PCIFR[2]=1 afterwards.
- Disabled latch:
  - set PCICR=0 and PCMSK0=0xFF;
  - toggle gpio_pin_in_b to 0x55 and check PCIFR=0x01 with irq=0;
  - write PCICR=0x01 and check irq[0]=1.
- Handshake:
  - hold mem_valid for 4 cycles on a PCMSK2=0xA5 write and check it commits once;
  - check mem_ready high from cycle 2 until valid drops, and PCMSK2 reads 0xA5;
  - assert rst_n low mid-access and check all outputs are 0.
